// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative divider.
//   op_t    : funct3[1:0] encoding of DIV/DIVU/REM/REMU
//   state_t : divider control states
//   CNT_W   : step-counter width for the default 32-bit datapath
package div_pkg;
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_t;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  // Counter width for an arbitrary datapath width (holds WIDTH-1).
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/paso_resta_restauradora.sv
// One restoring-division step (combinational).
//   i_rem  : partial remainder (always < i_dvsr)
//   i_bit  : next dividend bit shifted into the remainder
//   i_dvsr : divisor magnitude
//   o_rem  : new partial remainder
//   o_q    : quotient bit produced by this step
// The shifted remainder is WIDTH+1 bits wide so divisors with the MSB set
// never lose the top remainder bit.
module paso_resta_restauradora #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_brw;

  assign w_shift = {i_rem, i_bit};

  // Ripple subtract-with-borrow over the low WIDTH bits.
  always_comb begin
    w_brw  = 1'b0;
    w_diff = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_diff[k] = w_shift[k] ^ i_dvsr[k] ^ w_brw;
      w_brw     = (~w_shift[k] & i_dvsr[k]) | (~(w_shift[k] ^ i_dvsr[k]) & w_brw);
    end
  end

  // Top bit subtracts zero: no final borrow if it is set or nothing propagates.
  assign o_q   = w_shift[WIDTH] | ~w_brw;
  assign o_rem = o_q ? w_diff : w_shift[WIDTH-1:0];
endmodule

// File: rtl/divisor_iterativo.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
//   clk, rst        : clock, synchronous active-high reset
//   start, op       : request and funct3[1:0] operation
//   dividend/divisor: operands sampled on accept
//   abort           : pipeline flush, kills the operation in progress
//   busy, done      : status; done is a one-cycle result-valid pulse
//   result          : quotient or remainder, held until replaced
// Optional: define DIV_EARLY_EXIT_EN to skip the iteration when
// |dividend| < |divisor| (result is identical, latency drops to 2).
module divisor_iterativo
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = cnt_width(WIDTH);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_quo, r_rem, r_dvsr, r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q, r_neg_r, r_sel_rem;

  op_t              w_op;
  logic             w_accept, w_signed, w_a_neg, w_b_neg;
  logic             w_div0, w_ovf, w_special, w_early;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_spec_res;
  logic [WIDTH-1:0] w_step_rem, w_quo_fix, w_rem_fix;
  logic             w_step_q;

  assign w_op     = op_t'(op);
  assign w_accept = start & ~abort & (r_state == IDLE);
  assign w_signed = (w_op == OP_DIV) | (w_op == OP_REM);
  assign w_a_neg  = w_signed & dividend[WIDTH-1];
  assign w_b_neg  = w_signed & divisor[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -dividend : dividend;
  assign w_b_mag  = w_b_neg ? -divisor  : divisor;

  assign w_div0    = (divisor == '0);
  assign w_ovf     = w_signed & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&divisor);
  assign w_special = w_div0 | w_ovf;
  // Divide by zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
  assign w_spec_res = w_div0 ? (op[1] ? dividend : '1)
                             : (op[1] ? '0 : dividend);

`ifdef DIV_EARLY_EXIT_EN
  assign w_early = ~w_div0 & (w_a_mag < w_b_mag);
`else
  assign w_early = 1'b0;
`endif

  paso_resta_restauradora #(.WIDTH(WIDTH)) u_paso (
    .i_rem  (r_rem),
    .i_bit  (r_quo[WIDTH-1]),
    .i_dvsr (r_dvsr),
    .o_rem  (w_step_rem),
    .o_q    (w_step_q)
  );

  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_special ? DONE : (w_early ? FIX : CALC);
      CALC: if (abort) w_next = IDLE;
            else if (r_cnt == '0) w_next = FIX;
      FIX:  w_next = abort ? IDLE : DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvsr    <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_neg_q   <= w_a_neg ^ w_b_neg;
          r_neg_r   <= w_a_neg;
          r_sel_rem <= op[1];
          r_dvsr    <= w_b_mag;
          r_cnt     <= CW'(WIDTH-1);
          if (w_special) r_result <= w_spec_res;
          // Early exit lands directly in FIX with the answer already formed.
          if (w_early) begin
            r_quo <= '0;
            r_rem <= w_a_mag;
          end else begin
            r_quo <= w_a_mag;
            r_rem <= '0;
          end
        end
        CALC: if (!abort) begin
          r_rem <= w_step_rem;
          r_quo <= {r_quo[WIDTH-2:0], w_step_q};
          r_cnt <= r_cnt - CW'(1);
        end
        FIX: if (!abort) r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign result = r_result;
endmodule
